// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HIGH    = 2'b11,
    ST_WAIT_LO = 2'b10
  } state_e;

  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, async active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounces a raw level into q with one-cycle rise/fall pulses.
// DEBOUNCE_SYNC_EN selects a two-flop synchroniser; otherwise a single input register.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic d_s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_raw),
    .q     (d_s)
  );
`else
  logic d_s_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_s_q <= 1'b0;
    else       d_s_q <= d_raw;
  end
  assign d_s = d_s_q;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // cnt holds the number of consecutive samples disagreeing with q
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (d_s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!d_s) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!d_s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (d_s) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        q_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Input conditioning stage that sits directly upstream of the behavioural D flip-flop and latch: it takes a raw, possibly bouncing asynchronous level (push-button or external pin), synchronises it to `clk`, and drives a clean level `q` suitable for the flop's `D` input. It also emits single-cycle `rise`/`fall` pulses. The output changes only after the input has held a new value for `STABLE_CYCLES` consecutive clocks.

## Interface
- `STABLE_CYCLES`, default 4: consecutive agreeing samples required to change `q`; legal range ≥ 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: counter width; derived, not overridden.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `d_raw`  in  1  raw asynchronous input level.
- `q`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse when `q` goes 0→1.
- `fall`  out  1  one-cycle pulse when `q` goes 1→0.
- `busy`  out  1  high while a candidate transition is being qualified (WAIT states).

## Operation
- Input path: `d_raw` passes through a synchroniser chain of depth `SYNC_DEPTH` (see Configuration). The last stage is `d_s`.
- FSM states: `LOW`, `WAIT_HI`, `HIGH`, `WAIT_LO`. The counter `cnt` counts consecutive cycles in which `d_s != q`.
- `LOW`:
  - `d_s=1` → `WAIT_HI`, `cnt=1`.
  - Otherwise stay, `cnt=0`.
- `WAIT_HI`:
  - `d_s=0` → `LOW`, `cnt=0`. The glitch is discarded with no output activity.
  - `d_s=1` and `cnt==STABLE_CYCLES-1` → `HIGH`, `q<=1`, `rise<=1`, `cnt=0`.
  - Otherwise `cnt++`.
- `HIGH`/`WAIT_LO`: mirror image of the above, with `fall<=1`.
- `rise`/`fall` are registered and high for exactly one clock, coincident with the first cycle of the new `q`. They are never both high.
- `busy = (state==WAIT_HI || state==WAIT_LO)`.
- `cnt` never exceeds `STABLE_CYCLES-1` and never wraps.

## Timing
- Reset values: all sync flops 0, state `LOW`, `cnt=0`, `q=0`, `rise=0`, `fall=0`, `busy=0`.
- Reset is asynchronous. Asserting it mid-qualification aborts the pending transition immediately.
- After reset is released, a `d_raw` already at 1 is qualified normally. It produces `rise` after the full latency; there is no suppression.
- Latency: `d_raw` changes before edge k and stays stable. `q`, `rise`/`fall` update at edge k + SYNC_DEPTH − 1 + STABLE_CYCLES.
- With `SYNC_DEPTH=2` and `STABLE_CYCLES=4`, the update is at edge k+5.
- A pulse held for fewer than `STABLE_CYCLES` cycles at `d_s` never reaches `q`.
- A pulse of exactly `STABLE_CYCLES` cycles is accepted.
- After a reversal during WAIT, counting restarts from 1 on the next disagreeing sample.

## Configuration
- `DEBOUNCE_SYNC_EN`:
  - Defined: two-flop synchroniser, `SYNC_DEPTH=2`. Required whenever `d_raw` is truly asynchronous.
  - Undefined: single input register, `SYNC_DEPTH=1`. Latency drops by one cycle; intended only for inputs already synchronous to `clk`.
- FSM and counter behaviour are identical in both builds.

## Structure
- Shared package `debounce_pkg`:
  - State encodings `ST_LOW=2'b00`, `ST_WAIT_HI=2'b01`, `ST_HIGH=2'b11`, `ST_WAIT_LO=2'b10`.
  - Default `STABLE_CYCLES`.
- Sub-module `sync_2ff`: a reusable synchroniser with async active-high reset, ports `clk`, `reset`, `d`, `q`. It is instantiated only when `DEBOUNCE_SYNC_EN` is defined.
- FSM, counter and pulse generation are in `debounce_filter` itself.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `DEBOUNCE_SYNC_EN` defined, and a 10 ns clock.
- **Reset:** hold `reset=1` with `d_raw` toggling → `q=0`, `rise=0`, `fall=0`, `busy=0` throughout.
- **Clean rise:** release reset, set `d_raw=1` before edge k and hold → `busy` high from edge k+2, `q=1` and `rise=1` for one cycle at edge k+5, `busy=0` after.
- **Glitch rejection:** `d_raw=1` for 3 cycles, then 0 → `busy` pulses, `q` stays 0, `rise` never asserts.
- **Bounce then settle:** pattern 1,0,1,1,0,1 then steady 1 → `q` rises exactly 5 cycles after the final 0→1, with a single `rise` pulse.
- **Fall:** from `q=1`, set `d_raw=0` and hold → `q=0` and `fall=1` for one cycle, k+5 cycles after the change.
- **Reset mid-wait:** assert `reset` while `busy=1` with `cnt=2` → `q=0`, `busy=0` immediately (asynchronous). After release, the held `d_raw=1` rises `q` after a full 5-cycle latency.
